// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and types for the pwm generator and pwm_capture
package pwm_pkg;

  localparam int PWM_DWC = 8;  // default counter/data width
  localparam int PWM_CHN = 1;  // default channel count

  typedef logic [PWM_DWC-1:0] pwm_dat_t;  // duty / range value

endpackage

// File: rtl/pwm_capture_sync.sv
// rtl/pwm_capture_sync.sv - pwm input register, or 2-flop synchronizer under PWM_CAPTURE_SYNC_EN
//
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   pwm   [W] raw pwm inputs
//   smp   [W] registered/synchronized samples
//
// PWM_CAPTURE_SYNC_EN defined: two flops per bit (pin inputs).
// Not defined: one flop per bit (same-clock loopback only).
module pwm_capture_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] pwm,
  output logic [W-1:0] smp
);

`ifdef PWM_CAPTURE_SYNC_EN
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= '0;
      smp  <= '0;
    end else begin
      meta <= pwm;
      smp  <= meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      smp <= '0;
    end else begin
      smp <= pwm;
    end
  end
`endif

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures pwm high time per fixed window and streams the counts
//
// Ports:
//   clk      clock
//   rstn     asynchronous active-low reset
//   cke      synchronous clock enable (one sample per cke cycle)
//   ena      enable; low clears window, accumulators, pending output and ovf
//   rng      [DWC] window length in cke cycles (0 = no windows)
//   pwm      [CHN] pwm inputs
//   str_dat  [CHN*DWC] high count per channel, channel 0 in the low bits
//   str_vld  output valid
//   str_rdy  downstream ready
//   ovf      sticky overrun flag
//
// Macro PWM_CAPTURE_SYNC_EN selects a 2-flop input synchronizer (see pwm_capture_sync).
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int DWC = PWM_DWC,
  parameter int CHN = PWM_CHN
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cke,
  input  logic               ena,
  input  logic [DWC-1:0]     rng,
  input  logic [CHN-1:0]     pwm,
  output logic [CHN*DWC-1:0] str_dat,
  output logic               str_vld,
  input  logic               str_rdy,
  output logic               ovf
);

  logic [CHN-1:0]          smp;
  logic [DWC-1:0]          win;
  logic [CHN-1:0][DWC-1:0] acc;
  logic [CHN-1:0][DWC-1:0] res;
  logic                    step;
  logic                    eow;
  logic                    cap;

  pwm_capture_sync #(.W(CHN)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .pwm  (pwm),
    .smp  (smp)
  );

  // rng == 0 is excluded explicitly so rng-1 wrapping to all-ones never ends a window.
  assign step = ena & cke;
  assign eow  = step & (rng != '0) & (win == rng - DWC'(1));
  // The output register accepts a new result if empty or emptying this cycle.
  assign cap  = eow & (~str_vld | str_rdy);

  // Running count including the current sample; this is the window result at eow.
  always_comb begin
    res = '0;
    for (int i = 0; i < CHN; i++) begin
      res[i] = acc[i] + DWC'(smp[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win     <= '0;
      acc     <= '0;
      str_dat <= '0;
      str_vld <= 1'b0;
      ovf     <= 1'b0;
    end else if (!ena) begin
      // str_dat is left as is; dropping str_vld discards it.
      win     <= '0;
      acc     <= '0;
      str_vld <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (rng == '0 || eow) begin
        win <= '0;
        acc <= '0;
      end else if (cke) begin
        win <= win + DWC'(1);
        acc <= res;
      end

      if (cap) begin
        str_dat <= res;
        str_vld <= 1'b1;
      end else if (str_rdy) begin
        str_vld <= 1'b0;
      end

      // Result arriving while the previous one is still stalled is dropped.
      if (eow && str_vld && !str_rdy) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;

  localparam int DWC = 8;
  localparam int CHN = 1;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               cke = 1'b0;
  logic               ena = 1'b0;
  logic [DWC-1:0]     rng = '0;
  logic [CHN-1:0]     pwm = '0;
  logic [CHN*DWC-1:0] str_dat;
  logic               str_vld;
  logic               str_rdy = 1'b0;
  logic               ovf;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference generator: phase counter advancing on cke, high while phase < dat.
  int gph  = 0;
  int gdat = 0;
  int gdiv = 1;
  int cyc  = 0;

  typedef struct {
    int r;
    int d;
    int div;
    int exp;
  } vec_t;

  vec_t vt[8];

  always #5 clk = ~clk;

  pwm_capture #(.DWC(DWC), .CHN(CHN)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .cke     (cke),
    .ena     (ena),
    .rng     (rng),
    .pwm     (pwm),
    .str_dat (str_dat),
    .str_vld (str_vld),
    .str_rdy (str_rdy),
    .ovf     (ovf)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock: wait past the edge, advance the generator, drive new inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cke) begin
      if (int'(rng) == 0 || gph + 1 >= int'(rng)) gph = 0;
      else gph = gph + 1;
    end
    cyc++;
    cke = ((cyc % gdiv) == 0);
    pwm = (gph < gdat) ? '1 : '0;
  endtask

  task automatic setup(input int r, input int d, input int div, input logic rdy);
    ena     = 1'b0;
    rng     = DWC'(r);
    gdat    = d;
    gdiv    = div;
    gph     = 0;
    str_rdy = rdy;
    tick();
    tick();
    ena = 1'b1;
  endtask

  task automatic wait_vld(input string name, input int budget);
    int c;
    c = 0;
    while (!str_vld && c < budget) begin
      tick();
      c++;
    end
    if (!str_vld) check(name, 0, 1);
  endtask

  initial begin
    int got, last, budget, d1, stable, n, nv;

    vt[0] = '{r: 100, d: 37,  div: 1, exp: 37};
    vt[1] = '{r: 100, d: 0,   div: 1, exp: 0};
    vt[2] = '{r: 100, d: 100, div: 1, exp: 100};
    vt[3] = '{r: 10,  d: 4,   div: 3, exp: 4};
    vt[4] = '{r: 1,   d: 1,   div: 1, exp: 1};
    vt[5] = '{r: 1,   d: 0,   div: 1, exp: 0};
    vt[6] = '{r: 255, d: 255, div: 1, exp: 255};
    vt[7] = '{r: 7,   d: 3,   div: 2, exp: 3};

    // Reset state
    tick();
    tick();
    check("reset_vld", int'(str_vld), 0);
    check("reset_dat", int'(str_dat), 0);
    check("reset_ovf", int'(ovf), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Table: discard three results, check value of the 4th and 5th and their spacing.
    for (int i = 0; i < 8; i++) begin
      setup(vt[i].r, vt[i].d, vt[i].div, 1'b1);
      got    = 0;
      last   = 0;
      budget = vt[i].r * vt[i].div * 8 + 40;
      for (int c = 0; c < budget && got < 5; c++) begin
        tick();
        if (str_vld && str_rdy) begin
          got++;
          if (got >= 4) check($sformatf("vec%0d_dat", i), int'(str_dat), vt[i].exp);
          if (got == 5) check($sformatf("vec%0d_spacing", i), c - last, vt[i].r * vt[i].div);
          last = c;
        end
      end
      if (got < 5) check($sformatf("vec%0d_timeout", i), got, 5);
    end

    // Overrun: stall 2.5 windows, first result held, then released.
    setup(10, 3, 1, 1'b0);
    wait_vld("ovr_first_timeout", 40);
    d1     = int'(str_dat);
    stable = 1;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (!str_vld || int'(str_dat) != d1) stable = 0;
    end
    check("ovr_held_stable", stable, 1);
    check("ovr_flag", int'(ovf), 1);
    str_rdy = 1'b1;
    tick();
    if (!str_vld) wait_vld("ovr_next_timeout", 15);
    check("ovr_next_dat", int'(str_dat), 3);
    check("ovr_sticky", int'(ovf), 1);

    // ena drop with a pending result and ovf set.
    str_rdy = 1'b0;
    wait_vld("ena_pend_timeout", 15);
    for (int c = 0; c < 12; c++) tick();
    check("ena_pre_ovf", int'(ovf), 1);
    ena = 1'b0;
    tick();
    check("ena_low_vld", int'(str_vld), 0);
    check("ena_low_ovf", int'(ovf), 0);
    str_rdy = 1'b1;
    ena     = 1'b1;
    n = 0;
    while (!str_vld && n < 30) begin
      tick();
      n++;
    end
    check("ena_restart_len", n, 10);

    // rng == 0: no windows.
    setup(0, 0, 1, 1'b1);
    nv = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (str_vld) nv++;
    end
    check("rng0_no_vld", nv, 0);

    // Asynchronous reset mid-window with a stalled result and ovf set.
    setup(10, 10, 1, 1'b0);
    wait_vld("rst_pend_timeout", 40);
    for (int c = 0; c < 15; c++) tick();
    check("rst_pre_vld", int'(str_vld), 1);
    check("rst_pre_ovf", int'(ovf), 1);
    rstn = 1'b0;
    #1;
    check("rst_async_vld", int'(str_vld), 0);
    check("rst_async_dat", int'(str_dat), 0);
    check("rst_async_ovf", int'(ovf), 0);
    @(negedge clk);
    rstn = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart of the `pwm` generator. Samples CHN external PWM lines and measures each line's high time over a fixed window of `rng` enabled clock cycles. Emits one DWC-bit duty value per channel per window on a valid/ready stream. Sits between the PWM pins (or a `pwm` loopback) and the register/DMA stream logic.

## Interface
- `DWC`, 8: counter/data width; `rng` and duty values are DWC bits.
- `CHN`, 1: number of PWM input channels.

- `clk`  in  1  clock
- `rstn`  in  1  reset; asynchronous assert, active-low
- `cke`  in  1  synchronous clock enable; one sample per cycle with `cke`=1
- `ena`  in  1  enable; low clears the measurement state
- `rng`  in  DWC  window length in `cke` cycles; must equal the generator's `rng`
- `pwm`  in  CHN  PWM inputs, asynchronous to `clk`
- `str_dat`  out  CHN×DWC  measured high count per channel
- `str_vld`  out  1  output valid
- `str_rdy`  in  1  downstream ready
- `ovf`  out  1  sticky overrun flag

## Operation
- Input path: each `pwm[i]` is registered (see Configuration) to give `smp[i]`.
- Window counter `win` (DWC bits):
  - Advances on `ena & cke`.
  - Window end `eow = ena & cke & (win == rng-1)`; `win` goes to 0 at `eow`.
  - `rng == 0`: no windows, `eow` never fires, accumulators held at 0.
  - `rng == 1`: every `cke` cycle is a window end.
- Accumulator `acc[i]` (DWC bits):
  - On `ena & cke & ~eow`: `acc[i] += smp[i]`.
  - On `eow`: the result is `acc[i] + smp[i]` and `acc[i]` returns to 0.
  - The maximum result is `rng` ≤ 2^DWC−1, so no overflow and no saturation logic is needed.
- Output register (one deep):
  - Captures all CHN results at `eow` when the register is empty or being consumed in the same cycle (`~str_vld | str_rdy`), and sets `str_vld`.
  - The transfer completes on `str_vld & str_rdy`. `str_vld` clears unless a new `eow` capture happens in the same cycle.
  - `str_dat` is stable while `str_vld & ~str_rdy`.
- Overrun: when `eow` fires and `str_vld & ~str_rdy`, the new result is dropped, the old result is kept, and `ovf` is set.
- `ena` low, effective the next cycle:
  - `win`, `acc`, `str_vld` and `ovf` go to 0.
  - A pending output is discarded.
- Window phase is arbitrary relative to the PWM phase. For a periodic input with period `rng`, every full window returns exactly the generator's `dat`.

## Timing
- Reset values: `str_vld` = 0, `str_dat` = 0, `ovf` = 0, `win` = 0, `acc` = 0, and all synchronizer flops = 0.
- Input latency from pin to `smp`: 2 cycles with the macro, 1 cycle without.
- `str_vld` rises the cycle after `eow`, and `str_dat` is valid in that same cycle.
- Back-to-back windows with `str_rdy` held high give a sustained rate of one transfer per `rng` `cke` cycles.
- The first window after `ena` rises is full-length, but it contains up to 2 stale synchronizer samples. Software discards the first result.
- A `rstn` assertion mid-window aborts immediately with no output.

## Configuration
- `PWM_CAPTURE_SYNC_EN` defined:
  - Each `pwm[i]` passes through a 2-flop synchronizer before `smp`.
  - Use for pin inputs.
- Not defined:
  - A single register only.
  - Only for a same-clock loopback from `pwm`.
  - Latency is 1 cycle shorter. Results are identical.

## Structure
- Shared package `pwm_pkg`: default `DWC` and `CHN` constants, and the typedef `pwm_dat_t` (DWC-bit duty/range). Both `pwm` and `pwm_capture` use it.
- One sub-module, `pwm_capture_sync`:
  - Per-bit input register, or a 2-flop synchronizer under the macro.
  - Width CHN, with async reset.
- The window counter, accumulators and output stage are in the top module.

## Test plan
- Loopback from `pwm` with DWC=8, rng=100, dat=37 and `str_rdy`=1: every result after the first is 37.
- dat=0 and dat=100 (rng=100): results are 0 and 100. For dat=100 the input is constant high and the count equals `rng`.
- `cke` toggling 1-of-3 with rng=10 and the input high for 4 `cke` cycles: result is 4, one transfer per 30 clocks.
- `str_rdy` held low for 2.5 windows: the first result is held stable, `ovf` = 1, and the second and third results are dropped. With `str_rdy` high, the first result transfers and the next `eow` result follows.
- Drop `ena` with `str_vld`=1 and `ovf`=1: next cycle `str_vld` = 0 and `ovf` = 0. After re-enable, the count restarts from `win` = 0.
- rng=0 for 1000 cycles: `str_vld` stays 0. Assert `rstn` low mid-window: all outputs go to 0 asynchronously.
